// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a shadow/active value
// pair so a new value only reaches the display on a frame boundary.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_DEFAULT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic        ready,
  output logic [3:0]  hex,
  output logic [3:0]  digit_an,
  output logic        dp_out,
  output logic        frame_tick
);

  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic        act_lz_q, act_lz_d;
  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        sh_lz_q, sh_lz_d;
  logic        pend_q, pend_d;
  logic [3:0]  hex_q, hex_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic        tick_q, tick_d;

  logic        div_last;
  logic        wrap;
  logic        blank;
  logic [15:0] upper;

  always_comb begin
    div_last  = (div_q == 16'(REFRESH_DIV - 1));
    wrap      = enable && div_last && (idx_q == 2'd3);

    div_d     = div_q;
    idx_d     = idx_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_lz_d  = act_lz_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_lz_d   = sh_lz_q;
    pend_d    = pend_q;

    if (!enable) begin
      div_d = '0;
      idx_d = '0;
    end else if (div_last) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + 16'd1;
    end

    // Commit needs pend_q, so a load taken on a wrap edge waits a full frame.
    if (pend_q && (wrap || !enable)) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      act_lz_d  = sh_lz_q;
      pend_d    = 1'b0;
    end else if (load && !pend_q) begin
      sh_val_d = value;
      sh_dp_d  = dp_in;
      sh_lz_d  = lz_en;
      pend_d   = 1'b1;
    end

    // Nibbles at and above the current slot; all-zero means a leading zero.
    upper = act_val_q >> {idx_q, 2'b00};
    blank = act_lz_q && (idx_q != 2'd0) && (upper == '0);

    hex_d  = '0;
    an_d   = '1;
    dp_d   = 1'b0;
    tick_d = wrap;
    if (enable && !blank) begin
      hex_d = upper[3:0];
      an_d  = ~(4'b0001 << idx_q);
      dp_d  = act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_lz_q  <= LZ_DEFAULT;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_lz_q   <= 1'b0;
      pend_q    <= 1'b0;
      hex_q     <= '0;
      an_q      <= '1;
      dp_q      <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_lz_q  <= act_lz_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_lz_q   <= sh_lz_d;
      pend_q    <= pend_d;
      hex_q     <= hex_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign ready      = ~pend_q;
  assign hex        = hex_q;
  assign digit_an   = an_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl, checked against a
// cycle-count based reference model of the scan and shadow/active behaviour.
module tb_seg_scan_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        ready;
  logic [3:0]  hex;
  logic [3:0]  digit_an;
  logic        dp_out;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_cyc;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_dp, m_sh_dp;
  logic        m_lz, m_sh_lz, m_pend;
  logic [3:0]  e_hex, e_an;
  logic        e_dp, e_tick;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .LZ_DEFAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_en(lz_en), .ready(ready), .hex(hex),
    .digit_an(digit_an), .dp_out(dp_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_val = '0; m_dp = '0; m_lz = 1'b1;
    m_sh_val = '0; m_sh_dp = '0; m_sh_lz = 1'b0; m_pend = 1'b0;
    e_hex = '0; e_an = 4'hF; e_dp = 1'b0; e_tick = 1'b0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".hex"}, {12'd0, hex}, {12'd0, e_hex});
    chk({where, ".digit_an"}, {12'd0, digit_an}, {12'd0, e_an});
    chk({where, ".dp_out"}, {15'd0, dp_out}, {15'd0, e_dp});
    chk({where, ".frame_tick"}, {15'd0, frame_tick}, {15'd0, e_tick});
    chk({where, ".ready"}, {15'd0, ready}, {15'd0, ~m_pend});
  endtask

  // One clock: predict from the pre-edge model state and inputs, then compare.
  task automatic step();
    int          sl;
    bit          bnd, cmt, acc;
    logic [15:0] up;
    logic [3:0]  onehot;
    sl  = (m_cyc / RD) % 4;
    bnd = enable && ((m_cyc % (4 * RD)) == (4 * RD - 1));
    e_hex = '0; e_an = 4'hF; e_dp = 1'b0;
    if (enable) begin
      up = m_val >> (4 * sl);
      if (!(m_lz && sl != 0 && up == 16'd0)) begin
        onehot = 4'b0001 << sl;
        e_hex  = up[3:0];
        e_an   = ~onehot;
        e_dp   = m_dp[sl];
      end
    end
    e_tick = bnd;
    cmt = m_pend && (bnd || !enable);
    acc = load && !m_pend;
    if (cmt) begin
      m_val = m_sh_val; m_dp = m_sh_dp; m_lz = m_sh_lz; m_pend = 1'b0;
    end else if (acc) begin
      m_sh_val = value; m_sh_dp = dp_in; m_sh_lz = lz_en; m_pend = 1'b1;
    end
    m_cyc = enable ? m_cyc + 1 : 0;
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
    load = 1'b1; value = v; dp_in = d; lz_en = z;
    step();
    load = 1'b0;
  endtask

  initial begin
    int guard;
    logic [15:0] rv;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // blank scan after reset: only slot 0 lit
    enable = 1'b1;
    run(20);

    // mid-frame load, no suppression, dp on digit 2
    do_load(16'h12AF, 4'b0100, 1'b0);
    run(40);

    do_load(16'h00C0, 4'b0000, 1'b1);
    run(40);
    do_load(16'h0000, 4'b1111, 1'b1);
    run(40);

    // second load while pending is ignored
    do_load(16'h5678, 4'b0001, 1'b0);
    do_load(16'h9999, 4'b1000, 1'b0);
    run(40);

    // load exactly on the frame-boundary edge
    guard = 0;
    while (!(((m_cyc % (4 * RD)) == (4 * RD - 1)) && !m_pend) && guard < 200) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL boundary_wait observed=timeout expected=boundary within 200 cycles");
    end
    do_load(16'h4321, 4'b0010, 1'b0);
    run(40);

    // disable with a load: dark, commit on next edge, restart at slot 0
    enable = 1'b0;
    do_load(16'h0A0B, 4'b0101, 1'b1);
    run(6);
    enable = 1'b1;
    run(36);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 11) != 0);
      load   = ($urandom_range(0, 5) == 0);
      rv = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 1) rv[4*k +: 4] = 4'($urandom_range(0, 15));
      value = rv;
      dp_in = 4'($urandom);
      lz_en = 1'($urandom);
      step();
    end
    load = 1'b0;

    // async reset mid-slot with a pending load
    enable = 1'b1;
    run(5);
    do_load(16'h0BEE, 4'b1111, 1'b0);
    run(2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    run(24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
